// File: rtl/rhd_emu_pkg.sv
// Shared definitions for the RHD chip emulator: command opcodes, register-file
// size, ROM addresses/contents and the LFSR tap set used for sample generation.
package rhd_emu_pkg;

    // Top two bits of a command word select the operation class.
    typedef enum logic [1:0] {
        OP_CONVERT = 2'b00,
        OP_MISC    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_READ    = 2'b11
    } op_t;

    localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
    localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

    // Writable registers occupy addresses 0..NUM_WR_REGS-1.
    localparam int NUM_WR_REGS = 22;

    // Register 4 bit 6 selects two's-complement sample output.
    localparam int REG_CFG      = 4;
    localparam int CFG_TWOS_BIT = 6;

    localparam logic [5:0] ROM_ADDR_NAME  = 6'd40;   // 40..44 = "INTAN"
    localparam logic [5:0] ROM_ADDR_REV   = 6'd60;
    localparam logic [5:0] ROM_ADDR_UNI   = 6'd61;
    localparam logic [5:0] ROM_ADDR_NCH   = 6'd62;
    localparam logic [5:0] ROM_ADDR_CHIP  = 6'd63;
    localparam logic [7:0] ROM_REV_VALUE  = 8'h01;
    localparam logic [7:0] ROM_UNI_VALUE  = 8'h01;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form: state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] rom_value(input logic [5:0] addr,
                                             input int num_ch,
                                             input int chip_id);
        logic [7:0] v;
        v = 8'h00;
        case (addr)
            ROM_ADDR_NAME:         v = 8'h49;  // 'I'
            ROM_ADDR_NAME + 6'd1:  v = 8'h4E;  // 'N'
            ROM_ADDR_NAME + 6'd2:  v = 8'h54;  // 'T'
            ROM_ADDR_NAME + 6'd3:  v = 8'h41;  // 'A'
            ROM_ADDR_NAME + 6'd4:  v = 8'h4E;  // 'N'
            ROM_ADDR_REV:          v = ROM_REV_VALUE;
            ROM_ADDR_UNI:          v = ROM_UNI_VALUE;
            ROM_ADDR_NCH:          v = num_ch[7:0];
            ROM_ADDR_CHIP:         v = chip_id[7:0];
            default:               v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rhd_spi_frontend.sv
// SPI slave front end for the RHD emulator. Brings SCLK/MOSI/CS into the clk
// domain through 2-flop synchronizers, detects edges, shifts the command word in
// MSB first and counts SCLK rising edges to qualify each CS-framed word.
//   clk, rstn   : system clock, synchronous active-low reset
//   sclk/mosi/cs: raw SPI inputs from the master
//   sclk_fall   : SCLK falling edge while CS is low (TX shift strobe)
//   cs_fall     : CS falling edge (TX load strobe)
//   word_valid  : one-cycle pulse, CS rose after exactly 16 SCLK rising edges
//   word_err    : one-cycle pulse, CS rose after any other edge count
//   rx_word     : last 16 bits shifted in
module rhd_spi_frontend (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        sclk_fall,
    output logic        cs_fall,
    output logic        word_valid,
    output logic        word_err,
    output logic [15:0] rx_word
);

    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] cs_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic [4:0] bit_cnt;
    logic       sclk_rise;
    logic       cs_rise;
    logic       cs_s;

    assign cs_s      = cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev & ~cs_s;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev & ~cs_s;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_sync  <= 2'b00;
            mosi_sync  <= 2'b00;
            // CS synchronizer resets to idle so a word already in progress at
            // release is seen as a fresh (and therefore short) frame.
            cs_sync    <= 2'b11;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
            bit_cnt    <= 5'd0;
            rx_word    <= 16'h0000;
            word_valid <= 1'b0;
            word_err   <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[0], sclk};
            mosi_sync  <= {mosi_sync[0], mosi};
            cs_sync    <= {cs_sync[0], cs};
            sclk_prev  <= sclk_sync[1];
            cs_prev    <= cs_s;
            word_valid <= cs_rise && (bit_cnt == 5'd16);
            word_err   <= cs_rise && (bit_cnt != 5'd16);
            if (cs_fall) begin
                bit_cnt <= 5'd0;
            end else if (sclk_rise) begin
                // Saturate just past 16 so long frames can never alias to 16.
                if (bit_cnt < 5'd17) bit_cnt <= bit_cnt + 5'd1;
                rx_word <= {rx_word[14:0], mosi_sync[1]};
            end
        end
    end

endmodule

// File: rtl/rhd_chip_emulator.sv
// Behavioural emulator of an RHD-style amplifier chip's SPI command interface.
// Decodes CONVERT / CALIBRATE / CLEAR / WRITE / READ, keeps a 22-entry register
// file, generates counting or LFSR samples, and returns each result two words
// later through a pipe0/pipe1 pipeline, with an optional MISO cable delay.
//   clk, rstn  : system clock, synchronous active-low reset
//   SCLK/MOSI/CS: SPI from master (CS active low)
//   MISO       : response bit stream
//   word_done  : one-cycle pulse per valid 16-bit word
//   proto_err  : one-cycle pulse per malformed word
import rhd_emu_pkg::*;

module rhd_chip_emulator #(
    parameter logic [15:0] STARTING_SEED = 16'd0,
    parameter int          NUM_CHANNELS  = 64,
    parameter int          CHIP_ID       = 4,
    parameter int          PATTERN       = 0,
    parameter int          CABLE_DELAY   = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic SCLK,
    input  logic MOSI,
    input  logic CS,
    output logic MISO,
    output logic word_done,
    output logic proto_err
);

    localparam logic [15:0] LFSR_SEED = STARTING_SEED | 16'h0001;

    logic        sclk_fall;
    logic        cs_fall;
    logic        word_valid;
    logic        word_err;
    logic [15:0] rx_word;

    logic [15:0] pipe0;
    logic [15:0] pipe1;
    logic [15:0] tx_sr;
    logic [15:0] frame_cnt;
    logic [15:0] lfsr;
    logic [7:0]  regs [0:NUM_WR_REGS-1];

    logic [5:0]  addr;
    logic [15:0] result;
    logic [15:0] sample;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic        conv_hit;
    logic        clr;

    rhd_spi_frontend u_frontend (
        .clk        (clk),
        .rstn       (rstn),
        .sclk       (SCLK),
        .mosi       (MOSI),
        .cs         (CS),
        .sclk_fall  (sclk_fall),
        .cs_fall    (cs_fall),
        .word_valid (word_valid),
        .word_err   (word_err),
        .rx_word    (rx_word)
    );

    assign word_done = word_valid;
    assign proto_err = word_err;
    assign addr      = rx_word[13:8];

    always_comb begin
        rd_data  = 8'h00;
        sample   = 16'h0000;
        result   = 16'h0000;
        wr_en    = 1'b0;
        conv_hit = 1'b0;
        clr      = 1'b0;

        if (int'(addr) < NUM_WR_REGS) rd_data = regs[addr[4:0]];
        else                          rd_data = rom_value(addr, NUM_CHANNELS, CHIP_ID);

        sample = (PATTERN == 1) ? lfsr : (STARTING_SEED + {10'd0, addr} + frame_cnt);
        if (regs[REG_CFG][CFG_TWOS_BIT]) sample = sample ^ 16'h8000;

        case (op_t'(rx_word[15:14]))
            OP_CONVERT: begin
                if (int'(addr) < NUM_CHANNELS) begin
                    conv_hit = 1'b1;
                    result   = sample;
                end
            end
            OP_WRITE: begin
                wr_en  = 1'b1;
                result = {8'hFF, rx_word[7:0]};
            end
            OP_READ: begin
                if (rx_word[7:0] == 8'h00) result = {8'h00, rd_data};
            end
            default: begin
                // Calibration is a no-op in the emulator; only CLEAR has state.
                case (rx_word)
                    CMD_CLEAR:     clr = 1'b1;
                    CMD_CALIBRATE: clr = 1'b0;
                    default:       clr = 1'b0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pipe0     <= 16'h0000;
            pipe1     <= 16'h0000;
            tx_sr     <= 16'h0000;
            frame_cnt <= 16'h0000;
            lfsr      <= LFSR_SEED;
            for (int i = 0; i < NUM_WR_REGS; i++) regs[i] <= 8'h00;
        end else begin
            if (cs_fall)        tx_sr <= pipe1;
            else if (sclk_fall) tx_sr <= {tx_sr[14:0], 1'b0};

            if (word_valid) begin
                pipe1 <= pipe0;
                pipe0 <= result;
                if (wr_en && int'(addr) < NUM_WR_REGS) regs[addr[4:0]] <= rx_word[7:0];
                if (conv_hit) begin
                    if (int'(addr) == NUM_CHANNELS - 1) frame_cnt <= frame_cnt + 16'd1;
                    if (PATTERN == 1) lfsr <= lfsr_next(lfsr);
                end
                if (clr) begin
                    frame_cnt <= 16'h0000;
                    lfsr      <= LFSR_SEED;
                end
            end
        end
    end

    generate
        if (CABLE_DELAY == 0) begin : g_no_delay
            assign MISO = tx_sr[15];
        end else begin : g_delay
            logic [CABLE_DELAY-1:0] dly;
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dly <= '0;
                end else begin
                    dly[0] <= tx_sr[15];
                    for (int i = 1; i < CABLE_DELAY; i++) dly[i] <= dly[i-1];
                end
            end
            assign MISO = dly[CABLE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_rhd_chip_emulator.sv
// Self-checking bench for rhd_chip_emulator. Three instances share one SPI bus:
//   a: counting, seed 64, 64 channels, no cable delay
//   b: same as a with CABLE_DELAY = 3
//   c: LFSR, seed 64 (LFSR seed 65), 32 channels
// Expected responses are pushed to per-pattern queues as words are sent and
// popped two words later when the matching MISO response arrives.
module tb_rhd_chip_emulator;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs = 1'b1;
    logic miso_a, miso_b, miso_c;
    logic wd_a, wd_b, wd_c;
    logic pe_a, pe_b, pe_c;

    always #5 clk = ~clk;

    rhd_chip_emulator #(.STARTING_SEED(16'd64), .NUM_CHANNELS(64), .CHIP_ID(4),
                        .PATTERN(0), .CABLE_DELAY(0)) dut_a (
        .clk(clk), .rstn(rstn), .SCLK(sclk), .MOSI(mosi), .CS(cs),
        .MISO(miso_a), .word_done(wd_a), .proto_err(pe_a));

    rhd_chip_emulator #(.STARTING_SEED(16'd64), .NUM_CHANNELS(64), .CHIP_ID(4),
                        .PATTERN(0), .CABLE_DELAY(3)) dut_b (
        .clk(clk), .rstn(rstn), .SCLK(sclk), .MOSI(mosi), .CS(cs),
        .MISO(miso_b), .word_done(wd_b), .proto_err(pe_b));

    rhd_chip_emulator #(.STARTING_SEED(16'd64), .NUM_CHANNELS(32), .CHIP_ID(4),
                        .PATTERN(1), .CABLE_DELAY(0)) dut_c (
        .clk(clk), .rstn(rstn), .SCLK(sclk), .MOSI(mosi), .CS(cs),
        .MISO(miso_c), .word_done(wd_c), .proto_err(pe_c));

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0]  m_regs [0:21];
    logic [15:0] m_frame;
    logic [15:0] m_lfsr;
    logic [15:0] q_cnt[$];
    logic [15:0] q_lfsr[$];

    // Pulse counters and MISO transition timestamps
    int cyc = 0;
    int wd_cnt_a = 0, wd_cnt_b = 0, wd_cnt_c = 0;
    int pe_cnt_a = 0, pe_cnt_b = 0, pe_cnt_c = 0;
    logic pa = 1'b0, pb = 1'b0;
    int ta[$];
    int tb[$];

    always @(negedge clk) begin
        cyc++;
        if (wd_a === 1'b1) wd_cnt_a++;
        if (wd_b === 1'b1) wd_cnt_b++;
        if (wd_c === 1'b1) wd_cnt_c++;
        if (pe_a === 1'b1) pe_cnt_a++;
        if (pe_b === 1'b1) pe_cnt_b++;
        if (pe_c === 1'b1) pe_cnt_c++;
        if (miso_a !== pa) ta.push_back(cyc);
        if (miso_b !== pb) tb.push_back(cyc);
        pa = miso_a;
        pb = miso_b;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [7:0] model_read(input logic [5:0] a, input int nch);
        if (a < 6'd22) return m_regs[a];
        case (a)
            6'd40: return 8'h49;
            6'd41: return 8'h4E;
            6'd42: return 8'h54;
            6'd43: return 8'h41;
            6'd44: return 8'h4E;
            6'd60: return 8'h01;
            6'd61: return 8'h01;
            6'd62: return nch[7:0];
            6'd63: return 8'h04;
            default: return 8'h00;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
        m_frame = 16'h0000;
        m_lfsr  = 16'h0041;
        q_cnt.delete();
        q_lfsr.delete();
        q_cnt.push_back(16'h0000);
        q_cnt.push_back(16'h0000);
        q_lfsr.push_back(16'h0000);
        q_lfsr.push_back(16'h0000);
    endtask

    task automatic model_step(input logic [15:0] w, output logic [15:0] r_cnt,
                              output logic [15:0] r_lfsr);
        logic [5:0] a;
        logic [7:0] d;
        a = w[13:8];
        d = w[7:0];
        r_cnt  = 16'h0000;
        r_lfsr = 16'h0000;
        case (w[15:14])
            2'b00: begin
                // Counting instance has 64 channels, so every 6-bit C is in range.
                r_cnt = 16'd64 + {10'd0, a} + m_frame;
                if (m_regs[4][6]) r_cnt = r_cnt ^ 16'h8000;
                if (a == 6'd63) m_frame = m_frame + 16'd1;
                if (a < 6'd32) begin
                    r_lfsr = m_lfsr;
                    if (m_regs[4][6]) r_lfsr = r_lfsr ^ 16'h8000;
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                end
            end
            2'b01: begin
                if (w == 16'h6A00) begin
                    m_frame = 16'h0000;
                    m_lfsr  = 16'h0041;
                end
            end
            2'b10: begin
                r_cnt  = {8'hFF, d};
                r_lfsr = {8'hFF, d};
                if (a < 6'd22) m_regs[a] = d;
            end
            default: begin
                if (d == 8'h00) begin
                    r_cnt  = {8'h00, model_read(a, 64)};
                    r_lfsr = {8'h00, model_read(a, 32)};
                end
            end
        endcase
    endtask

    // One CS-framed transfer of nbits SCLK cycles; MISO sampled before each rise.
    task automatic xfer(input logic [15:0] w, input int nbits,
                        output logic [15:0] ra, output logic [15:0] rb, output logic [15:0] rc);
        ra = 16'h0000;
        rb = 16'h0000;
        rc = 16'h0000;
        cs = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) mosi = w[15-i];
            else        mosi = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            if (i < 16) begin
                ra[15-i] = miso_a;
                rb[15-i] = miso_b;
                rc[15-i] = miso_c;
            end
            sclk = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            sclk = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        cs = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Valid word: transfer, update the model, and hand back the expected responses.
    task automatic issue(input logic [15:0] w, output logic [15:0] ra, output logic [15:0] rb,
                         output logic [15:0] rc, output logic [15:0] ea, output logic [15:0] ec);
        logic [15:0] r1, r2;
        xfer(w, 16, ra, rb, rc);
        ea = q_cnt.pop_front();
        ec = q_lfsr.pop_front();
        model_step(w, r1, r2);
        q_cnt.push_back(r1);
        q_lfsr.push_back(r2);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({miso_a, miso_b, miso_c, wd_a, wd_b, wd_c, pe_a, pe_b, pe_c} !== 9'b0)
            $display("FAIL reset_outputs: got %b want 000000000",
                     {miso_a, miso_b, miso_c, wd_a, wd_b, wd_c, pe_a, pe_b, pe_c});
        else n_pass++;
        rstn = 1'b1;
        reset_model();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_list(input string name, input logic [15:0] words[$]);
        logic [15:0] ra, rb, rc, ea, ec;
        foreach (words[k]) begin
            issue(words[k], ra, rb, rc, ea, ec);
            n_checks++;
            if (ra !== ea) $display("FAIL %s_a[%0d] cmd %h: got %h want %h", name, k, words[k], ra, ea);
            else n_pass++;
            n_checks++;
            if (rb !== ea) $display("FAIL %s_b[%0d] cmd %h: got %h want %h", name, k, words[k], rb, ea);
            else n_pass++;
            n_checks++;
            if (rc !== ec) $display("FAIL %s_c[%0d] cmd %h: got %h want %h", name, k, words[k], rc, ec);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic [15:0] ra, rb, rc, ea, ec;
        logic [15:0] words[$];
        words = '{16'h85A5, 16'hC500};
        run_list("wr_rd", words);
        issue(16'hC500, ra, rb, rc, ea, ec);
        n_checks++;
        if (ra !== 16'hFFA5) $display("FAIL write_ack: got %h want FFA5", ra);
        else n_pass++;
        issue(16'hC500, ra, rb, rc, ea, ec);
        n_checks++;
        if (ra !== 16'h00A5) $display("FAIL read_back: got %h want 00A5", ra);
        else n_pass++;
        n_checks++;
        if (rc !== ec) $display("FAIL read_back_c: got %h want %h", rc, ec);
        else n_pass++;
    endtask

    task automatic test_rom();
        logic [15:0] words[$];
        // ROM, IDs, an unimplemented address, a malformed READ, a write to a
        // read-only address followed by a read of it, then flush words.
        words = '{16'hE800, 16'hE900, 16'hEA00, 16'hEB00, 16'hEC00,
                  16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00, 16'hED00, 16'hC501,
                  16'h9E77, 16'hDE00, 16'hD500, 16'h5500, 16'h5500};
        run_list("rom", words);
    endtask

    task automatic test_convert();
        logic [15:0] words[$];
        logic [15:0] ra, rb, rc, ea, ec;
        words = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        run_list("conv", words);
        issue(16'h8440, ra, rb, rc, ea, ec);
        issue(16'h0000, ra, rb, rc, ea, ec);
        issue(16'h5500, ra, rb, rc, ea, ec);
        issue(16'h5500, ra, rb, rc, ea, ec);
        n_checks++;
        if (ra !== 16'h8040) $display("FAIL conv_twos: got %h want 8040", ra);
        else n_pass++;
        n_checks++;
        if (rc !== ec) $display("FAIL conv_twos_c: got %h want %h", rc, ec);
        else n_pass++;
        // Frame wrap, out-of-range channel on the 32-channel instance, CLEAR.
        words = '{16'h8400, 16'h3F00, 16'h0000, 16'h2000, 16'h3F00, 16'h0500,
                  16'h6A00, 16'h0000, 16'h0100, 16'h5500, 16'h5500};
        run_list("conv2", words);
    endtask

    task automatic test_proto_err();
        logic [15:0] ra, rb, rc;
        int wd0, pe0;
        run_list("pe_pre", '{16'h8912, 16'hC900});
        wd0 = wd_cnt_a;
        pe0 = pe_cnt_a;
        xfer(16'h8B33, 10, ra, rb, rc);
        n_checks++;
        if (pe_cnt_a - pe0 !== 1) $display("FAIL proto_err_short: got %0d pulses want 1", pe_cnt_a - pe0);
        else n_pass++;
        n_checks++;
        if (wd_cnt_a - wd0 !== 0) $display("FAIL word_done_short: got %0d pulses want 0", wd_cnt_a - wd0);
        else n_pass++;
        xfer(16'h8C44, 17, ra, rb, rc);
        n_checks++;
        if (pe_cnt_b - pe0 !== 2 || pe_cnt_c - pe0 !== 2)
            $display("FAIL proto_err_long: got %0d/%0d pulses want 2", pe_cnt_b - pe0, pe_cnt_c - pe0);
        else n_pass++;
        run_list("pe_post", '{16'hCB00, 16'hCC00, 16'h5500, 16'h5500});
        n_checks++;
        if (wd_cnt_a - wd0 !== 4 || wd_cnt_c - wd0 !== 4)
            $display("FAIL word_done_cnt: got %0d/%0d want 4", wd_cnt_a - wd0, wd_cnt_c - wd0);
        else n_pass++;
    endtask

    task automatic test_cable_delay();
        int n;
        ta.delete();
        tb.delete();
        run_list("dly", '{16'h8A5A, 16'hCA00, 16'h5500, 16'h5500});
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (ta.size() != tb.size() || ta.size() == 0)
            $display("FAIL delay_edges: got %0d delayed edges want %0d (nonzero)", tb.size(), ta.size());
        else n_pass++;
        n = (ta.size() < tb.size()) ? ta.size() : tb.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (tb[i] - ta[i] != 3) $display("FAIL delay_lag[%0d]: got %0d cycles want 3", i, tb[i] - ta[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midword();
        logic [15:0] w;
        logic [15:0] ra, rb, rc, ea, ec;
        run_list("rst_pre", '{16'h85A5, 16'hC500, 16'h0700});
        w = 16'hC500;
        cs = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            mosi = w[15-i];
            repeat (4) @(posedge clk);
            #1;
            sclk = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            sclk = 1'b0;
            if (i == 5) begin
                rstn = 1'b0;
                @(posedge clk);
                #1;
                n_checks++;
                if ({miso_a, miso_b, miso_c, wd_a, wd_b, wd_c, pe_a, pe_b, pe_c} !== 9'b0)
                    $display("FAIL midword_reset_outputs: got %b want 000000000",
                             {miso_a, miso_b, miso_c, wd_a, wd_b, wd_c, pe_a, pe_b, pe_c});
                else n_pass++;
                rstn = 1'b1;
                repeat (3) @(posedge clk);
            end else begin
                repeat (4) @(posedge clk);
            end
            #1;
        end
        cs = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        reset_model();
        issue(16'hC500, ra, rb, rc, ea, ec);
        n_checks++;
        if (ra !== 16'h0000 || rc !== 16'h0000) $display("FAIL post_reset_1: got %h/%h want 0000", ra, rc);
        else n_pass++;
        issue(16'h5500, ra, rb, rc, ea, ec);
        n_checks++;
        if (ra !== 16'h0000 || rb !== 16'h0000) $display("FAIL post_reset_2: got %h/%h want 0000", ra, rb);
        else n_pass++;
        run_list("rst_post", '{16'h5500, 16'h0000, 16'h5500, 16'h5500});
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rom();
        test_convert();
        test_proto_err();
        test_cable_delay();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
